thresh_result_checker: RTL
==========================

# thresh_result_checker

Hardware result checker for the 4-procedure thresholding datapath. After the thresholding engine has written its binary image into the output SRAM (Sram_Operand instance B), this block reads it back, reads a reference image from a second Sram_Operand instance (R) at the same addresses, and counts matching and mismatching pixels. It sits beside the thresholding engine on the output memory's read side, so a run can be checked on-chip or on an FPGA without a simulator compare loop.

## Interface
- A_WIDTH, 17, SRAM address width
- D_WIDTH, 8, pixel/data width
- NUM_PIXELS, 76800, number of addresses scanned (0 .. NUM_PIXELS-1); must be ≥1 and ≤ 2^A_WIDTH
- C_WIDTH, 17, width of the match/mismatch counters; must hold NUM_PIXELS
- Clk  in  1  single clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low
- Go  in  1  start pulse, sampled only in IDLE or DONE
- Addr  out  A_WIDTH  shared read address to both SRAMs
- B_Data  in  D_WIDTH  read data from the output SRAM
- R_Data  in  D_WIDTH  read data from the reference SRAM
- B_En, R_En  out  1  SRAM enables, both driven identically
- B_RW, R_RW  out  1  SRAM read/write select, constant 0 (read)
- Busy  out  1  high from the first address issue through the last compare
- Done  out  1  high in DONE until the next accepted Go or reset
- Correct  out  C_WIDTH  count of equal pixel pairs
- Incorrect  out  C_WIDTH  count of unequal pixel pairs
- Fail_Seen  out  1  at least one mismatch (CHECKER_FAIL_CAPTURE_EN only)
- Fail_Addr  out  A_WIDTH  address of the first mismatch (CHECKER_FAIL_CAPTURE_EN only)

## Operation
- States: IDLE → READ → DRAIN → DONE → (Go) READ.
- IDLE/DONE + Go=1: clear Correct, Incorrect, Fail_Seen, and Fail_Addr; set Addr=0 and En=1; go to READ.
- READ: each cycle Addr increments by 1 with En=1. The compare of the previous address happens in the same cycle. After issuing NUM_PIXELS-1, go to DRAIN.
- DRAIN: En=0, Addr holds the last value, and the final compare is performed; go to DONE.
- Compare: B_Data == R_Data increments Correct; otherwise Incorrect increments. Exactly one counter increments per valid compare.
- At Done: Correct + Incorrect == NUM_PIXELS. The counters never wrap.
- Go while Busy is ignored and has no effect on the scan.
- Reset in any state returns to IDLE immediately. All outputs go to their reset values, and no partial counts are retained.

## Timing
- Reset values: Addr=0, B_En=R_En=0, B_RW=R_RW=0, Busy=0, Done=0, Correct=0, Incorrect=0, Fail_Seen=0, Fail_Addr=0.
- SRAM read latency is 1 cycle: address/enable presented at edge k yields data compared at edge k+1. A compare-valid flag is pipelined one cycle behind En.
- Go sampled at edge 0. Addr 0 is issued at edge 1. The last address is issued at edge NUM_PIXELS. The last compare and the transition to DONE happen at edge NUM_PIXELS+1, with Done=1 after that edge.
- Go→Done latency is NUM_PIXELS+1 cycles. Busy is high for exactly NUM_PIXELS+1 cycles.
- NUM_PIXELS=1: READ lasts one cycle and goes straight to DRAIN.
- Counters update on the compare edge and remain stable while Done=1.

## Configuration
- CHECKER_FAIL_CAPTURE_EN defined:
  - On the first mismatch of a scan, latch Addr-1 (the compared address) into Fail_Addr and set Fail_Seen. Later mismatches do not overwrite them.
  - Both outputs are cleared on an accepted Go.
- CHECKER_FAIL_CAPTURE_EN undefined:
  - Fail_Seen and Fail_Addr ports are absent, and no capture registers are built.
  - Counting behaviour is identical.

## Structure
- Shared package/include checker_defs:
  - A_WIDTH, D_WIDTH, C_WIDTH, and NUM_PIXELS defaults.
  - State encoding constants S_IDLE, S_READ, S_DRAIN, S_DONE.
- One sub-module, pixel_compare_counter, covering the compare-valid pipeline stage, the equality compare, the two counters, and the optional fail capture.
- The top level holds the FSM and address generator.

## Test plan
- Identical B and R images, NUM_PIXELS=76800, Go pulse → Done at Go+76801 cycles, Correct=76800, Incorrect=0, Busy high for 76801 cycles.
- R differs from B only at address 100 → Correct=76799, Incorrect=1, Fail_Seen=1, Fail_Addr=100.
- Mismatches at addresses 0, 1, and 76799 → Incorrect=3, Fail_Addr=0. Verifies the first and last pipeline slots.
- Go re-pulsed at address 5000 mid-scan → ignored; final counts match an undisturbed run, and Done arrives at the original cycle.
- Rst low at address 5000 → all outputs 0 asynchronously, state IDLE. A subsequent Go produces a full, correct scan (Correct=76800 for identical images).
- NUM_PIXELS=1, single differing word → Done 2 cycles after Go, Correct=0, Incorrect=1; a second Go from DONE clears the counters and repeats.

Source files
------------

// File: rtl/thresh_result_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : thresh_result_checker_pkg
//  Purpose  : Shared definitions for the thresholding result checker.
//             Holds the default widths and pixel count used as parameter
//             defaults, plus the scan state encoding.
//  Contents : DEF_A_WIDTH    - SRAM address width default
//             DEF_D_WIDTH    - pixel/data width default
//             DEF_NUM_PIXELS - pixel count default (320x240 image)
//             DEF_C_WIDTH    - match/mismatch counter width default
//             state_e        - S_IDLE / S_READ / S_DRAIN / S_DONE
//  Revision : 1.0 - initial release
// ============================================================================
package thresh_result_checker_pkg;

   localparam int DEF_A_WIDTH    = 17;
   localparam int DEF_D_WIDTH    = 8;
   localparam int DEF_NUM_PIXELS = 76800;
   localparam int DEF_C_WIDTH    = 17;

   // Scan sequencer states.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

endpackage : thresh_result_checker_pkg
`default_nettype wire

// File: rtl/thresh_result_checker_pixel_compare_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_compare_counter
//  Purpose  : Compare stage of the result checker. Tracks which SRAM reads
//             are in flight, compares the returned output/reference pixels
//             and counts matches and mismatches. Optionally records the
//             address of the first mismatch (CHECKER_FAIL_CAPTURE_EN).
//  Ports    : clk_i        - clock, rising edge
//             rst_ni       - asynchronous active-low reset
//             clr_i        - clears counters (and capture) on a new scan
//             en_i         - SRAM enable as presented to the memories
//             addr_i       - SRAM address as presented (capture build only)
//             b_data_i     - output SRAM read data
//             r_data_i     - reference SRAM read data
//             correct_o    - count of equal pixel pairs
//             incorrect_o  - count of unequal pixel pairs
//             fail_seen_o  - a mismatch was seen (capture build only)
//             fail_addr_o  - first mismatching address (capture build only)
//  Macros   : CHECKER_FAIL_CAPTURE_EN - builds the first-mismatch capture
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_compare_counter
   import thresh_result_checker_pkg::*;
#(
`ifdef CHECKER_FAIL_CAPTURE_EN
   parameter int A_WIDTH = DEF_A_WIDTH,
`endif
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int C_WIDTH = DEF_C_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               en_i,
`ifdef CHECKER_FAIL_CAPTURE_EN
   input  logic [A_WIDTH-1:0] addr_i,
`endif
   input  logic [D_WIDTH-1:0] b_data_i,
   input  logic [D_WIDTH-1:0] r_data_i,
   output logic [C_WIDTH-1:0] correct_o,
   output logic [C_WIDTH-1:0] incorrect_o
`ifdef CHECKER_FAIL_CAPTURE_EN
   ,
   output logic               fail_seen_o,
   output logic [A_WIDTH-1:0] fail_addr_o
`endif
);

   // The memories sample address/enable on the edge after they are
   // presented and return data one cycle later, so a read launched at
   // edge k is compared at edge k+1. valid_q marks that slot.
   logic               valid_q;
   logic [C_WIDTH-1:0] correct_q;
   logic [C_WIDTH-1:0] incorrect_q;
   logic               pix_match;

   assign pix_match = (b_data_i == r_data_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= en_i;
      end
   end

   // Exactly one counter moves per valid compare. A scan never compares
   // more than NUM_PIXELS pairs and C_WIDTH holds NUM_PIXELS, so neither
   // counter can wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         correct_q   <= '0;
         incorrect_q <= '0;
      end else if (clr_i) begin
         correct_q   <= '0;
         incorrect_q <= '0;
      end else if (valid_q) begin
         if (pix_match) begin
            correct_q <= correct_q + C_WIDTH'(1);
         end else begin
            incorrect_q <= incorrect_q + C_WIDTH'(1);
         end
      end
   end

   assign correct_o   = correct_q;
   assign incorrect_o = incorrect_q;

`ifdef CHECKER_FAIL_CAPTURE_EN
   // The address travels alongside valid_q so the captured value is the
   // address whose data is being compared, including the final compare
   // made while the sequencer holds the address in DRAIN.
   logic [A_WIDTH-1:0] cmp_addr_q;
   logic               fail_seen_q;
   logic [A_WIDTH-1:0] fail_addr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmp_addr_q <= '0;
      end else if (en_i) begin
         cmp_addr_q <= addr_i;
      end
   end

   // Only the first mismatch of a scan is recorded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fail_seen_q <= 1'b0;
         fail_addr_q <= '0;
      end else if (clr_i) begin
         fail_seen_q <= 1'b0;
         fail_addr_q <= '0;
      end else if (valid_q && !pix_match && !fail_seen_q) begin
         fail_seen_q <= 1'b1;
         fail_addr_q <= cmp_addr_q;
      end
   end

   assign fail_seen_o = fail_seen_q;
   assign fail_addr_o = fail_addr_q;
`endif

endmodule : pixel_compare_counter
`default_nettype wire

// File: rtl/thresh_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : thresh_result_checker
//  Purpose  : On-chip checker for the thresholding datapath. Scans the
//             output SRAM (B) and a reference SRAM (R) over addresses
//             0..NUM_PIXELS-1 with a shared address and counts matching
//             and mismatching pixel pairs.
//  Ports    : clk_i        - clock, rising edge
//             rst_ni       - asynchronous active-low reset
//             go_i         - start pulse, honoured only in IDLE or DONE
//             addr_o       - shared read address to both SRAMs
//             b_data_i     - output SRAM read data
//             r_data_i     - reference SRAM read data
//             b_en_o/r_en_o   - SRAM enables (identical)
//             b_rw_o/r_rw_o   - SRAM read/write select, always read (0)
//             busy_o       - first address issue through last compare
//             done_o       - scan complete, held until next Go or reset
//             correct_o    - count of equal pixel pairs
//             incorrect_o  - count of unequal pixel pairs
//             fail_seen_o  - a mismatch was seen (capture build only)
//             fail_addr_o  - first mismatching address (capture build only)
//  Macros   : CHECKER_FAIL_CAPTURE_EN - adds first-mismatch capture ports
//  Revision : 1.0 - initial release
// ============================================================================
module thresh_result_checker
   import thresh_result_checker_pkg::*;
#(
   parameter int A_WIDTH    = DEF_A_WIDTH,
   parameter int D_WIDTH    = DEF_D_WIDTH,
   parameter int NUM_PIXELS = DEF_NUM_PIXELS,
   parameter int C_WIDTH    = DEF_C_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               go_i,
   output logic [A_WIDTH-1:0] addr_o,
   input  logic [D_WIDTH-1:0] b_data_i,
   input  logic [D_WIDTH-1:0] r_data_i,
   output logic               b_en_o,
   output logic               r_en_o,
   output logic               b_rw_o,
   output logic               r_rw_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [C_WIDTH-1:0] correct_o,
   output logic [C_WIDTH-1:0] incorrect_o
`ifdef CHECKER_FAIL_CAPTURE_EN
   ,
   output logic               fail_seen_o,
   output logic [A_WIDTH-1:0] fail_addr_o
`endif
);

   localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NUM_PIXELS - 1);

   state_e             state_q;
   logic [A_WIDTH-1:0] addr_q;
   logic               en_q;
   logic               busy_q;
   logic               done_q;
   logic               start;

   // A Go is only accepted when no scan is in flight.
   assign start = go_i && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Sequencer and address generator. Address 0 and the enable are driven
   // right after the Go edge so the memories capture address 0 on the next
   // edge; the last address is captured on edge NUM_PIXELS, after which
   // DRAIN waits one cycle for its data to be compared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (go_i) begin
                  state_q <= S_READ;
                  addr_q  <= '0;
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_READ: begin
               if (addr_q == LAST_ADDR) begin
                  // Hold the last address; no further reads are launched.
                  state_q <= S_DRAIN;
                  en_q    <= 1'b0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            S_DRAIN: begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign addr_o = addr_q;
   assign b_en_o = en_q;
   assign r_en_o = en_q;
   assign b_rw_o = 1'b0;
   assign r_rw_o = 1'b0;
   assign busy_o = busy_q;
   assign done_o = done_q;

   pixel_compare_counter #(
`ifdef CHECKER_FAIL_CAPTURE_EN
      .A_WIDTH     (A_WIDTH),
`endif
      .D_WIDTH     (D_WIDTH),
      .C_WIDTH     (C_WIDTH)
   ) u_cmp (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (start),
      .en_i        (en_q),
`ifdef CHECKER_FAIL_CAPTURE_EN
      .addr_i      (addr_q),
      .fail_seen_o (fail_seen_o),
      .fail_addr_o (fail_addr_o),
`endif
      .b_data_i    (b_data_i),
      .r_data_i    (r_data_i),
      .correct_o   (correct_o),
      .incorrect_o (incorrect_o)
   );

endmodule : thresh_result_checker
`default_nettype wire
